// File: rtl/jtopl_eg_pkg.sv
// Shared types and constants for the time-multiplexed OPL envelope generator.
package jtopl_eg_pkg;

  typedef enum logic [1:0] {
    ATTACK  = 2'd0,
    DECAY   = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } eg_state_e;

  localparam int FCNTW = 15;

  // All-ones attenuation (silence) for an envelope of the given width.
  function automatic logic [31:0] eg_max(input int unsigned egw);
    return (32'd1 << egw) - 32'd1;
  endfunction

endpackage

// File: rtl/jtopl_eg_step.sv
// Combinational ADSR step: next level/state for the slot currently being processed.
module jtopl_eg_step
  import jtopl_eg_pkg::*;
#(
  parameter int EGW = 10
) (
  input  logic [EGW-1:0]   level,
  input  eg_state_e        state,
  input  logic [3:0]       arate,
  input  logic [3:0]       drate,
  input  logic [3:0]       rrate,
  input  logic [3:0]       sl,
  input  logic             en_sus,
  input  logic [FCNTW-1:0] fcnt,
  input  logic             kon_edge,
  input  logic             koff_edge,
  output logic [EGW-1:0]   level_nx,
  output eg_state_e        state_nx
);

  localparam logic [EGW-1:0] FULL = EGW'(eg_max(EGW));

  logic [3:0]       rate;
  logic [FCNTW-1:0] mask;
  logic             stp;
  logic [EGW-1:0]   thr;
  logic [EGW-1:0]   inc;
  logic [EGW-1:0]   atk;

  always_comb begin
    case (state)
      ATTACK:  rate = arate;
      DECAY:   rate = drate;
      SUSTAIN: rate = en_sus ? 4'd0 : rrate;
      default: rate = rrate;
    endcase
  end

  // Rate R steps when the low (15-R) frame-counter bits are all zero.
  assign mask = {FCNTW{1'b1}} >> rate;
  assign stp  = (rate != 4'd0) && ((fcnt & mask) == '0);
  assign thr  = (sl == 4'hF) ? FULL : {sl, {(EGW-4){1'b0}}};
  assign inc  = (level == FULL) ? FULL : level + 1'b1;
  assign atk  = (level == '0) ? '0 : level - (level >> 3) - 1'b1;

  always_comb begin
    level_nx = level;
    state_nx = state;
    if (kon_edge) begin
      state_nx = ATTACK;
      if (arate == 4'hF) begin
        level_nx = '0;
        state_nx = DECAY;
      end
    end else if (koff_edge) begin
      state_nx = RELEASE;
    end else if (stp) begin
      case (state)
        ATTACK: begin
          level_nx = atk;
          if (atk == '0) state_nx = DECAY;
        end
        DECAY: begin
          level_nx = inc;
          if (inc >= thr) state_nx = SUSTAIN;
        end
        default: level_nx = inc;
      endcase
    end
  end

endmodule

// File: rtl/jtopl_eg_seq.sv
// Time-multiplexed ADSR envelope generator: slot/frame counters, per-slot state, output registers.
// Define JTOPL_EG_AM_EN to add saturating LFO amplitude modulation on eg_out.
module jtopl_eg_seq
  import jtopl_eg_pkg::*;
#(
  parameter int SLOTS = 18,
  parameter int EGW   = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cen,
  output logic [$clog2(SLOTS)-1:0] slot,
  output logic                     zero,
  input  logic [SLOTS-1:0]         keyon,
  input  logic                     en_sus,
  input  logic [3:0]               arate,
  input  logic [3:0]               drate,
  input  logic [3:0]               rrate,
  input  logic [3:0]               sl,
  input  logic [3:0]               lfo_am,
  output logic [EGW-1:0]           eg_out,
  output logic [$clog2(SLOTS)-1:0] eg_slot,
  output logic                     eg_valid,
  output logic                     pg_rst
);

  localparam int              SW   = $clog2(SLOTS);
  localparam logic [EGW-1:0]  FULL = EGW'(eg_max(EGW));
  localparam logic [SW-1:0]   LAST = SW'(SLOTS - 1);

  logic [FCNTW-1:0] fcnt;
  logic [EGW-1:0]   level_mem [SLOTS];
  eg_state_e        state_mem [SLOTS];
  logic [SLOTS-1:0] kon_mem;

  logic             kon_edge;
  logic             koff_edge;
  logic [EGW-1:0]   level_nx;
  eg_state_e        state_nx;
  logic [EGW-1:0]   out_nx;

  assign zero      = (slot == '0);
  assign kon_edge  = keyon[slot] & ~kon_mem[slot];
  assign koff_edge = ~keyon[slot] & kon_mem[slot];

  jtopl_eg_step #(.EGW(EGW)) u_step (
    .level     (level_mem[slot]),
    .state     (state_mem[slot]),
    .arate     (arate),
    .drate     (drate),
    .rrate     (rrate),
    .sl        (sl),
    .en_sus    (en_sus),
    .fcnt      (fcnt),
    .kon_edge  (kon_edge),
    .koff_edge (koff_edge),
    .level_nx  (level_nx),
    .state_nx  (state_nx)
  );

`ifdef JTOPL_EG_AM_EN
  logic [EGW:0] am_sum;
  assign am_sum = {1'b0, level_nx} + (EGW+1)'({lfo_am, 2'b00});
  assign out_nx = am_sum[EGW] ? FULL : am_sum[EGW-1:0];
`else
  logic unused_am;
  assign unused_am = ^lfo_am;
  assign out_nx    = level_nx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot     <= '0;
      fcnt     <= '0;
      eg_out   <= FULL;
      eg_slot  <= '0;
      eg_valid <= 1'b0;
      pg_rst   <= 1'b0;
      kon_mem  <= '0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        level_mem[i] <= FULL;
        state_mem[i] <= RELEASE;
      end
    end else begin
      eg_valid <= cen;
      if (cen) begin
        level_mem[slot] <= level_nx;
        state_mem[slot] <= state_nx;
        kon_mem[slot]   <= keyon[slot];
        eg_out          <= out_nx;
        eg_slot         <= slot;
        pg_rst          <= kon_edge;
        if (slot == LAST) begin
          slot <= '0;
          fcnt <= fcnt + 1'b1;
        end else begin
          slot <= slot + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtopl_eg_seq.sv
// Self-checking bench for jtopl_eg_seq: directed table, ADSR corner sequences, randomized traffic vs. a reference model.
module tb_jtopl_eg_seq;

  localparam int SLOTS = 18;
  localparam int EGW   = 10;
  localparam int SW    = $clog2(SLOTS);
  localparam int FULL  = 1023;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cen = 1'b0;
  logic [SW-1:0]    slot;
  logic             zero;
  logic [SLOTS-1:0] keyon = '0;
  logic             en_sus = 1'b0;
  logic [3:0]       arate = '0, drate = '0, rrate = '0, sl = '0, lfo_am = '0;
  logic [EGW-1:0]   eg_out;
  logic [SW-1:0]    eg_slot;
  logic             eg_valid;
  logic             pg_rst;

  always #5 clk = ~clk;

  jtopl_eg_seq #(.SLOTS(SLOTS), .EGW(EGW)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .slot(slot), .zero(zero),
    .keyon(keyon), .en_sus(en_sus), .arate(arate), .drate(drate),
    .rrate(rrate), .sl(sl), .lfo_am(lfo_am), .eg_out(eg_out),
    .eg_slot(eg_slot), .eg_valid(eg_valid), .pg_rst(pg_rst)
  );

  // Reference model state (state numbering: 0 attack, 1 decay, 2 sustain, 3 release)
  int m_lvl [SLOTS];
  int m_st  [SLOTS];
  bit m_kon [SLOTS];
  int m_fcnt, m_slot, m_out, m_eslot;
  bit m_pg;

  // Per-slot configuration presented by the "register bank"
  int c_ar [SLOTS];
  int c_dr [SLOTS];
  int c_rr [SLOTS];
  int c_sl [SLOTS];
  bit c_sus [SLOTS];
  logic [SLOTS-1:0] kv = '0;
  int am_val = 0;
  int cap [SLOTS];

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int s; bit k; int ar; int dr; int rr; int sl; bit sus;
    int exp_out; bit exp_pg;
  } vec_t;
  vec_t tbl [7];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic m_reset();
    for (int s = 0; s < SLOTS; s++) begin
      m_lvl[s] = FULL; m_st[s] = 3; m_kon[s] = 1'b0;
    end
    m_fcnt = 0; m_slot = 0; m_out = FULL; m_eslot = 0; m_pg = 1'b0;
  endtask

  task automatic m_apply(input int s);
    int rate, lvl, st, thr;
    bit kon_e, koff_e, stp;
    lvl = m_lvl[s];
    st  = m_st[s];
    case (st)
      0: rate = c_ar[s];
      1: rate = c_dr[s];
      2: rate = c_sus[s] ? 0 : c_rr[s];
      default: rate = c_rr[s];
    endcase
    kon_e  = kv[s] && !m_kon[s];
    koff_e = !kv[s] && m_kon[s];
    stp    = (rate != 0) && ((m_fcnt % (1 << (15 - rate))) == 0);
    if (kon_e) begin
      st = 0;
      if (c_ar[s] == 15) begin lvl = 0; st = 1; end
    end else if (koff_e) begin
      st = 3;
    end else if (stp) begin
      if (st == 0) begin
        lvl = lvl - lvl / 8 - 1;
        if (lvl < 0) lvl = 0;
        if (lvl == 0) st = 1;
      end else begin
        lvl = (lvl + 1 > FULL) ? FULL : lvl + 1;
        if (st == 1) begin
          thr = (c_sl[s] == 15) ? FULL : c_sl[s] * 64;
          if (lvl >= thr) st = 2;
        end
      end
    end
    m_lvl[s] = lvl;
    m_st[s]  = st;
    m_kon[s] = kv[s];
    m_pg     = kon_e;
    m_eslot  = s;
`ifdef JTOPL_EG_AM_EN
    m_out = (lvl + am_val * 4 > FULL) ? FULL : lvl + am_val * 4;
`else
    m_out = lvl;
`endif
    m_slot = (s + 1) % SLOTS;
    if (m_slot == 0) m_fcnt = (m_fcnt + 1) % 32768;
  endtask

  task automatic cen_cycle();
    int s;
    s = m_slot;
    arate  = 4'(c_ar[s]);
    drate  = 4'(c_dr[s]);
    rrate  = 4'(c_rr[s]);
    sl     = 4'(c_sl[s]);
    en_sus = c_sus[s];
    keyon  = kv;
    lfo_am = 4'(am_val);
    cen    = 1'b1;
    @(posedge clk);
    #1;
    cen = 1'b0;
    m_apply(s);
    check("eg_valid", int'(eg_valid), 1);
    check("eg_slot", int'(eg_slot), m_eslot);
    check("eg_out", int'(eg_out), m_out);
    check("pg_rst", int'(pg_rst), int'(m_pg));
    check("slot", int'(slot), m_slot);
    check("zero", int'(zero), int'(m_slot == 0));
    cap[s] = int'(eg_out);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      check("idle_valid", int'(eg_valid), 0);
      check("idle_out", int'(eg_out), m_out);
      check("idle_slot", int'(slot), m_slot);
      check("idle_pg", int'(pg_rst), int'(m_pg));
    end
  endtask

  task automatic run_frames(input int n);
    repeat (n * SLOTS) cen_cycle();
  endtask

  task automatic run_to(input int s);
    while (m_slot != s) cen_cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_slot"}, int'(slot), 0);
    check({tag, "_zero"}, int'(zero), 1);
    check({tag, "_eg_out"}, int'(eg_out), FULL);
    check({tag, "_eg_slot"}, int'(eg_slot), 0);
    check({tag, "_eg_valid"}, int'(eg_valid), 0);
    check({tag, "_pg_rst"}, int'(pg_rst), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int prev;
    bit done;

    tbl[0] = '{3, 1'b1, 15, 0,  0, 4, 1'b0,    0, 1'b1};
    tbl[1] = '{3, 1'b1, 15, 0,  0, 4, 1'b0,    0, 1'b0};
    tbl[2] = '{5, 1'b1, 12, 0,  0, 4, 1'b0, 1023, 1'b1};
    tbl[3] = '{3, 1'b0, 15, 0,  0, 4, 1'b0,    0, 1'b0};
    tbl[4] = '{3, 1'b0, 15, 0, 15, 4, 1'b0,    1, 1'b0};
    tbl[5] = '{3, 1'b0, 15, 0, 15, 4, 1'b0,    2, 1'b0};
    tbl[6] = '{7, 1'b0,  0, 0, 15, 0, 1'b0, 1023, 1'b0};

    for (int s = 0; s < SLOTS; s++) begin
      c_ar[s] = 0; c_dr[s] = 0; c_rr[s] = 0; c_sl[s] = 0; c_sus[s] = 1'b0; cap[s] = 0;
    end
    m_reset();

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    idle(2);

    // Two idle frames: silence, no phase resets, slot sequence wraps
    run_frames(2);

    for (int i = 0; i < 7; i++) begin
      c_ar[tbl[i].s] = tbl[i].ar;
      c_dr[tbl[i].s] = tbl[i].dr;
      c_rr[tbl[i].s] = tbl[i].rr;
      c_sl[tbl[i].s] = tbl[i].sl;
      c_sus[tbl[i].s] = tbl[i].sus;
      kv[tbl[i].s] = tbl[i].k;
      run_to(tbl[i].s);
      cen_cycle();
      check($sformatf("tbl%0d_out", i), int'(eg_out), tbl[i].exp_out);
      check($sformatf("tbl%0d_pg", i), int'(pg_rst), int'(tbl[i].exp_pg));
    end

    // Slot 5: attack at rate 12 down to zero, then held since drate=0
    prev = cap[5];
    done = 1'b0;
    for (int f = 0; f < 800 && !done; f++) begin
      run_frames(1);
      check("atk_mono", int'(cap[5] <= prev), 1);
      prev = cap[5];
      if (cap[5] == 0) done = 1'b1;
    end
    check("atk_reach0", cap[5], 0);
    run_frames(20);
    check("dec_hold0", cap[5], 0);

    // Slot 2: instant attack, decay at rate 15 to sl=2 (0x080), sustain hold
    c_ar[2] = 15; c_dr[2] = 15; c_sl[2] = 2; c_sus[2] = 1'b1; c_rr[2] = 0; kv[2] = 1'b1;
    run_frames(1);
    check("b_kon0", cap[2], 0);
    run_frames(127);
    check("b_climb", cap[2], 127);
    run_frames(1);
    check("b_sus", cap[2], 'h080);
    run_frames(10);
    check("b_hold", cap[2], 'h080);

    // Slot 2: key-off, release at rate 15 saturates without wrapping
    kv[2] = 1'b0; c_rr[2] = 15;
    run_frames(1);
    check("c_koff", cap[2], 'h080);
    run_frames(1);
    check("c_rel1", cap[2], 'h081);
    run_frames(900);
    check("c_sat", cap[2], FULL);
    run_frames(5);
    check("c_nowrap", cap[2], FULL);

    // Randomized traffic with cen gaps
    for (int f = 0; f < 40; f++) begin
      for (int s = 0; s < SLOTS; s++) begin
        if ($urandom_range(0, 3) == 0) begin
          c_ar[s] = $urandom_range(0, 15);
          c_dr[s] = $urandom_range(0, 15);
          c_rr[s] = $urandom_range(0, 15);
          c_sl[s] = $urandom_range(0, 15);
          c_sus[s] = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 7) == 0) kv[s] = ~kv[s];
      end
      for (int i = 0; i < SLOTS; i++) begin
        am_val = $urandom_range(0, 15);
        cen_cycle();
        idle($urandom_range(0, 2));
      end
    end
    am_val = 0;

    // Asynchronous reset in the middle of a frame
    run_to(9);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    m_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("arst_hold");
    rst_n = 1'b1;
    cen_cycle();
    check("arst_first_slot", int'(eg_slot), 0);
    run_frames(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
